// File: rtl/frame_capture_rx.sv
// frame_capture_rx: captures hsync-qualified RGB pixels into frame-buffer RAM writes; BOTTOM_UP_EN selects BMP row order/packing; ports HCLK/HRESET/hsync/DATA_* in, mem_addr/mem_wdata/mem_we/line_done/frame_done/overrun out
module frame_capture_rx #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int ADDR_W = 19
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              hsync,
  input  logic [7:0]        DATA_R,
  input  logic [7:0]        DATA_G,
  input  logic [7:0]        DATA_B,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [23:0]       mem_wdata,
  output logic              mem_we,
  output logic              line_done,
  output logic              frame_done,
  output logic              overrun
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int RW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
`ifdef BOTTOM_UP_EN
  localparam logic [ADDR_W-1:0] A_START = ADDR_W'((HEIGHT - 1) * WIDTH);
  localparam logic [ADDR_W-1:0] A_WRAP  = ADDR_W'(2 * WIDTH - 1);
`else
  localparam logic [ADDR_W-1:0] A_START = '0;
`endif
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
  state_t            r_state, w_state_n;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [ADDR_W-1:0] r_addr, w_addr_n;
  logic              w_acc, w_eol, w_eof;
  logic [23:0]       w_pix;
  always_comb begin
    w_acc     = hsync && r_state != DONE;
    w_eol     = r_col == CW'(WIDTH - 1);
    w_eof     = w_eol && r_row == RW'(HEIGHT - 1);
    w_state_n = w_acc ? (w_eof ? DONE : CAPTURE) : r_state;
`ifdef BOTTOM_UP_EN
    w_pix     = {DATA_B, DATA_G, DATA_R};
    w_addr_n  = w_eof ? r_addr : w_eol ? r_addr - A_WRAP : r_addr + ADDR_W'(1);
`else
    w_pix     = {DATA_R, DATA_G, DATA_B};
    w_addr_n  = w_eof ? r_addr : r_addr + ADDR_W'(1);
`endif
  end
  always_ff @(posedge HCLK) r_state <= HRESET ? IDLE : w_state_n;
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_col      <= '0;
      r_row      <= '0;
      r_addr     <= A_START;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      mem_we     <= w_acc;
      line_done  <= w_acc && w_eol;
      frame_done <= frame_done | (w_acc && w_eof);
      overrun    <= overrun | (hsync && r_state == DONE);
      if (w_acc) begin
        mem_addr  <= r_addr;
        mem_wdata <= w_pix;
        r_col     <= w_eol ? '0 : r_col + CW'(1);
        r_row     <= (w_eol && !w_eof) ? r_row + RW'(1) : r_row;
        r_addr    <= w_addr_n;
      end
    end
  end
endmodule

// File: tb/tb_frame_capture_rx.sv
// tb_frame_capture_rx: randomized directed bench against an index-arithmetic reference model
module tb_frame_capture_rx;
  localparam int W = 4;
  localparam int H = 3;
  logic       HCLK = 0, HRESET = 1, hsync = 0;
  logic [7:0] DATA_R = 0, DATA_G = 0, DATA_B = 0;
  logic [3:0] mem_addr;
  logic [23:0] mem_wdata;
  logic       mem_we, line_done, frame_done, overrun;
  int compared = 0, mismatched = 0;
  int n = 0;
  logic e_we = 0, e_ld = 0, e_fd = 0, e_ov = 0;
  logic [31:0] e_addr = 0, e_wd = 0;
  frame_capture_rx #(.WIDTH(W), .HEIGHT(H), .ADDR_W(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .hsync(hsync),
    .DATA_R(DATA_R), .DATA_G(DATA_G), .DATA_B(DATA_B),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .line_done(line_done), .frame_done(frame_done), .overrun(overrun)
  );
  always #5 HCLK = ~HCLK;
  function automatic int exp_addr(input int i);
`ifdef BOTTOM_UP_EN
    return (H - 1 - i / W) * W + i % W;
`else
    return i;
`endif
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h (pixel %0d)", tag, got, exp, n);
    end
  endtask
  task automatic cyc(input logic rst, input logic hs, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    HRESET = rst; hsync = hs; DATA_R = r; DATA_G = g; DATA_B = b;
    @(posedge HCLK); #1;
    if (rst) begin
      n = 0; e_we = 0; e_ld = 0; e_fd = 0; e_ov = 0; e_addr = 0; e_wd = 0;
    end else if (hs && n < W * H) begin
      e_we = 1;
      e_addr = exp_addr(n);
`ifdef BOTTOM_UP_EN
      e_wd = {8'h0, b, g, r};
`else
      e_wd = {8'h0, r, g, b};
`endif
      e_ld = (n % W) == W - 1;
      e_fd = e_fd | (n == W * H - 1);
      n++;
    end else begin
      e_we = 0; e_ld = 0;
      if (hs) e_ov = 1;
    end
    check("mem_we", {31'h0, mem_we}, {31'h0, e_we});
    if (e_we || rst) begin
      check("mem_addr", {28'h0, mem_addr}, e_addr);
      check("mem_wdata", {8'h0, mem_wdata}, e_wd);
    end
    check("line_done", {31'h0, line_done}, {31'h0, e_ld});
    check("frame_done", {31'h0, frame_done}, {31'h0, e_fd});
    check("overrun", {31'h0, overrun}, {31'h0, e_ov});
  endtask
  task automatic rnd(input logic rst, input logic hs);
    cyc(rst, hs, 8'($urandom), 8'($urandom), 8'($urandom));
  endtask
  initial begin
    rnd(1, 0);
    rnd(1, 0);
    rnd(1, 1);
    for (int i = 0; i < 12; i++) cyc(0, 1, 8'(i), 8'h10, 8'h20);
    rnd(0, 1);
    rnd(0, 1);
    rnd(0, 0);
    rnd(0, 0);
    rnd(1, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, 8'(i), 8'h10, 8'h20);
      rnd(0, 0);
    end
    rnd(0, 1);
    rnd(1, 0);
    for (int i = 0; i < 6; i++) rnd(0, 1);
    rnd(1, 1);
    for (int i = 0; i < 12; i++) begin
      rnd(0, 1);
      repeat ($urandom_range(0, 2)) rnd(0, 0);
    end
    rnd(0, 1);
    rnd(0, 1);
    for (int i = 0; i < 400; i++) rnd($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
